// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES constants, FSM encodings and GF(2^8) helpers
package aes_pkg;

    localparam int BYTE_W = 8;
    localparam int COL_W  = 32;
    localparam logic [8:0] AES_POLY = 9'h11B;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Products of one byte by the four InvMixColumns coefficients
    typedef struct packed {
        logic [BYTE_W-1:0] m9;
        logic [BYTE_W-1:0] mb;
        logic [BYTE_W-1:0] md;
        logic [BYTE_W-1:0] me;
    } inv_mul_t;

    function automatic logic [BYTE_W-1:0] xtime(input logic [BYTE_W-1:0] b);
        return {b[BYTE_W-2:0], 1'b0} ^ (b[BYTE_W-1] ? AES_POLY[BYTE_W-1:0] : {BYTE_W{1'b0}});
    endfunction

    function automatic inv_mul_t inv_mul(input logic [BYTE_W-1:0] a);
        logic [BYTE_W-1:0] x2;
        logic [BYTE_W-1:0] x4;
        logic [BYTE_W-1:0] x8;
        inv_mul_t m;
        x2   = xtime(a);
        x4   = xtime(x2);
        x8   = xtime(x4);
        m.m9 = x8 ^ a;
        m.mb = x8 ^ x2 ^ a;
        m.md = x8 ^ x4 ^ a;
        m.me = x8 ^ x4 ^ x2;
        return m;
    endfunction

endpackage

// File: rtl/inv_mixcol_word.sv
// rtl/inv_mixcol_word.sv - combinational InvMixColumns of one 32-bit column
import aes_pkg::*;

module inv_mixcol_word (
    input  logic [COL_W-1:0] col,
    output logic [COL_W-1:0] res
);

    // byte 0 of the column sits in the most significant byte
    inv_mul_t m [4];

    always_comb begin
        for (int r = 0; r < 4; r++) begin
            m[r] = inv_mul(col[COL_W-1-BYTE_W*r -: BYTE_W]);
        end
        res[31:24] = m[0].me ^ m[1].mb ^ m[2].md ^ m[3].m9;
        res[23:16] = m[0].m9 ^ m[1].me ^ m[2].mb ^ m[3].md;
        res[15:8]  = m[0].md ^ m[1].m9 ^ m[2].me ^ m[3].mb;
        res[7:0]   = m[0].mb ^ m[1].md ^ m[2].m9 ^ m[3].me;
    end

endmodule

// File: rtl/inv_mixcol_seq.sv
// rtl/inv_mixcol_seq.sv - handshaked AES InvMixColumns engine (INV_MIXCOL_UNROLL_EN: all columns in one cycle)
import aes_pkg::*;

module inv_mixcol_seq #(
    parameter int NCOL = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [0:127] in_state,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [0:127] out_state
);

    state_t       state;
    state_t       state_nxt;
    logic [0:127] in_reg;
    logic         busy_last;

`ifdef INV_MIXCOL_UNROLL_EN
    logic [COL_W-1:0] col_res [NCOL];

    for (genvar c = 0; c < NCOL; c++) begin : g_col
        inv_mixcol_word u_word (
            .col (in_reg[COL_W*c +: COL_W]),
            .res (col_res[c])
        );
    end

    assign busy_last = 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_reg    <= '0;
            out_state <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) in_reg <= in_state;
                BUSY: begin
                    for (int c = 0; c < NCOL; c++) begin
                        out_state[COL_W*c +: COL_W] <= col_res[c];
                    end
                end
                default: ;
            endcase
        end
    end
`else
    localparam int CNT_W = $clog2(NCOL);

    logic [CNT_W-1:0] cnt;
    logic [COL_W-1:0] col_res;
    logic [6:0]       col_base;

    // NCOL is 4, so column c starts at bit 32c of the 128-bit state
    assign col_base  = {cnt, 5'd0};
    assign busy_last = (cnt == CNT_W'(NCOL - 1));

    inv_mixcol_word u_word (
        .col (in_reg[col_base +: COL_W]),
        .res (col_res)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_reg    <= '0;
            out_state <= '0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        in_reg <= in_state;
                        cnt    <= '0;
                    end
                end
                BUSY: begin
                    out_state[col_base +: COL_W] <= col_res;
                    cnt                          <= cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = BUSY;
            end
            BUSY: begin
                if (busy_last) state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: doc/inv_mixcol_seq.md
Name: inv_mixcol_seq

Overview:
- AES InvMixColumns engine for the decryption datapath; the inverse of the forward MixColumns block.
- Accepts one 128-bit state over a valid/ready handshake.
- Transforms one 32-bit column per cycle over 4 cycles, then holds the result until it is consumed downstream.
- Sits between InvShiftRows/InvSubBytes and AddRoundKey in the decrypt round.

Parameters:
- NCOL, 4, number of columns per state; fixed at 4 for AES, used to size the column counter.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  in_state is valid
- in_ready  output  1  block can accept a state
- in_state  input  [0:127]  state, column-major
  - column c = bits [32c : 32c+31]
  - byte r of column c = bits [32c+8r : 32c+8r+7]
- out_valid  output  1  out_state is valid
- out_ready  input  1  downstream accepts out_state
- out_state  output  [0:127]  InvMixColumns(in_state), same bit ordering as in_state

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, column counter=0, in_ready=1, out_valid=0, out_state=0, input register=0.
  - Asserting rst mid-operation aborts the transform; no partial result is ever presented.
- Per-column arithmetic, with a0..a3 = bytes 0..3 of the column:
  - b0 = 0e*a0 ^ 0b*a1 ^ 0d*a2 ^ 09*a3
  - b1 = 09*a0 ^ 0e*a1 ^ 0b*a2 ^ 0d*a3
  - b2 = 0d*a0 ^ 09*a1 ^ 0e*a2 ^ 0b*a3
  - b3 = 0b*a0 ^ 0d*a1 ^ 09*a2 ^ 0e*a3
  - Multiplication is in GF(2^8) modulo x^8+x^4+x^3+x+1 (9'h11B), built from xtime chains (x2, x4, x8).
- IDLE state:
  - in_ready=1.
  - On the edge with in_valid & in_ready, latch in_state into the input register, clear the counter, and go to BUSY.
- BUSY state:
  - in_ready=0.
  - Each edge writes the transformed column[cnt] into out_state[32cnt:32cnt+31] and increments cnt.
  - On the edge writing cnt=3, go to DONE and set out_valid=1.
- DONE state:
  - out_valid=1; out_state is held stable.
  - in_valid is ignored.
  - On the edge with out_ready=1, clear out_valid and go to IDLE.
- Latency and throughput:
  - out_valid rises 4 cycles after the accept edge.
  - Minimum accept-to-accept interval is 6 cycles: accept, 4 BUSY, DONE handshake, IDLE.
- Boundary conditions:
  - out_ready held low: DONE is held indefinitely and out_state does not change.
  - out_ready already high when DONE is entered: out_valid is high for exactly 1 cycle.
  - in_valid asserted in BUSY or DONE: no effect; upstream must hold the state until in_ready.
  - Counter wraps 3->0 on entering DONE.
- The block has no combinational path from in_* to out_*.

Optional Feature:
- Macro: INV_MIXCOL_UNROLL_EN
- When defined:
  - Four column instances are computed in parallel.
  - BUSY lasts exactly 1 cycle, so out_valid rises 1 cycle after the accept edge.
  - The column counter is removed.
- When undefined:
  - A single column instance is time-multiplexed over 4 BUSY cycles, as described above.
- Handshake rules and the DONE hold behaviour are identical in both builds.

Decomposition:
- Shared package aes_pkg holds:
  - AES_POLY = 9'h11B
  - state encodings IDLE/BUSY/DONE
  - the xtime function
  - the byte/column width constants 8 and 32
- Sub-module inv_mixcol_word: combinational, 32-bit column in to 32-bit column out, implementing the four b-equations above.

Test Plan:
- Single column: in_state = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6 -> out_state = 128'hdb135345_f20a225c_01010101_c6c6c6c6, with out_valid rising 4 cycles after accept.
- FIPS-197 C.1 round 1 inverse: in_state = 5f72641557f5bc92f7be3b291db9f91a -> out_state = 6353e08c0960e104cd70b751bacad0e7.
- Backpressure: hold out_ready=0 for 10 cycles after DONE -> out_valid stays 1, out_state stays constant, in_ready stays 0; then pulse out_ready -> IDLE next cycle.
- Back-to-back stream: in_valid held high with two states and out_ready=1 -> second accept occurs exactly 6 cycles after the first, and both results are correct.
- Reset mid-BUSY: assert rst at BUSY cnt=2 -> out_valid=0, out_state=0, in_ready=1 immediately; the next transform is correct.
- Round trip: random 1000 states through forward MixColumns then inv_mixcol_seq -> output equals the original; repeat with INV_MIXCOL_UNROLL_EN defined (latency 1).
